// File: rtl/guess_game_ctrl.sv
// rtl/guess_game_ctrl.sv - number-guessing round controller with registered hints
// Optional `GUESS_GAME_LFSR_EN: secret is taken from an internal 8-bit LFSR instead of the secret port.

module comparator8 #(
  parameter int n = 8
) (
  input  logic [n-1:0] main_number,
  input  logic [n-1:0] given_number,
  output logic         gt,
  output logic         lt,
  output logic         eq
);
  assign gt = main_number > given_number;
  assign lt = main_number < given_number;
  assign eq = main_number == given_number;
endmodule

module guess_game_ctrl #(
  parameter int N         = 8,
  parameter int MAX_TRIES = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] secret,
  input  logic         guess_valid,
  input  logic [N-1:0] guess,
  output logic         guess_ready,
  output logic         hint_valid,
  output logic         hint_up,
  output logic         hint_down,
  output logic         hint_eq,
  output logic [3:0]   tries,
  output logic         win,
  output logic         lose
);
  typedef enum logic [2:0] {IDLE, ARMED, CMP, WIN, LOSE} state_t;

  localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

  state_t       state_q, state_d;
  logic [N-1:0] secret_q, secret_d;
  logic [N-1:0] guess_q, guess_d;
  logic [3:0]   tries_q, tries_d;
  logic         guess_ready_q, guess_ready_d;
  logic         hint_valid_q, hint_valid_d;
  logic         hint_up_q, hint_up_d;
  logic         hint_down_q, hint_down_d;
  logic         hint_eq_q, hint_eq_d;
  logic         win_q, win_d;
  logic         lose_q, lose_d;
  logic         cmp_gt, cmp_lt, cmp_eq;
  logic         accept;
  logic [N-1:0] load_value;

`ifdef GUESS_GAME_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 8'h5A;
    else     lfsr_q <= lfsr_d;
  end

  assign load_value = N'(lfsr_q);
`else
  assign load_value = secret;
`endif

  comparator8 #(.n(N)) u_cmp (
    .main_number  (secret_q),
    .given_number (guess_q),
    .gt           (cmp_gt),
    .lt           (cmp_lt),
    .eq           (cmp_eq)
  );

  assign accept = (state_q == ARMED) && guess_ready_q && guess_valid && !load;

  always_comb begin
    state_d      = state_q;
    secret_d     = secret_q;
    guess_d      = guess_q;
    tries_d      = tries_q;
    hint_valid_d = 1'b0;
    hint_up_d    = hint_up_q;
    hint_down_d  = hint_down_q;
    hint_eq_d    = hint_eq_q;
    win_d        = win_q;
    lose_d       = lose_q;
    if (load) begin
      secret_d = load_value;
      tries_d  = 4'd0;
      win_d    = 1'b0;
      lose_d   = 1'b0;
      state_d  = ARMED;
    end else begin
      case (state_q)
        ARMED: begin
          if (accept) begin
            guess_d = guess;
            tries_d = tries_q + 4'd1;
            state_d = CMP;
          end
        end
        CMP: begin
          hint_valid_d = 1'b1;
          hint_up_d    = cmp_gt;
          hint_down_d  = cmp_lt;
          hint_eq_d    = cmp_eq;
          if (cmp_eq) begin
            win_d   = 1'b1;
            state_d = WIN;
          end else if (tries_q == MAX_T) begin
            lose_d  = 1'b1;
            state_d = LOSE;
          end else begin
            state_d = ARMED;
          end
        end
        default: state_d = state_q;
      endcase
    end
    // The cycle that returns from CMP carries the hint, so readiness waits one more cycle.
    guess_ready_d = !load && (state_q == ARMED) && (state_d == ARMED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      secret_q      <= '0;
      guess_q       <= '0;
      tries_q       <= 4'd0;
      guess_ready_q <= 1'b0;
      hint_valid_q  <= 1'b0;
      hint_up_q     <= 1'b0;
      hint_down_q   <= 1'b0;
      hint_eq_q     <= 1'b0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      secret_q      <= secret_d;
      guess_q       <= guess_d;
      tries_q       <= tries_d;
      guess_ready_q <= guess_ready_d;
      hint_valid_q  <= hint_valid_d;
      hint_up_q     <= hint_up_d;
      hint_down_q   <= hint_down_d;
      hint_eq_q     <= hint_eq_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
    end
  end

  assign guess_ready = guess_ready_q;
  assign hint_valid  = hint_valid_q;
  assign hint_up     = hint_up_q;
  assign hint_down   = hint_down_q;
  assign hint_eq     = hint_eq_q;
  assign tries       = tries_q;
  assign win         = win_q;
  assign lose        = lose_q;
endmodule

// File: doc/guess_game_ctrl.md
GUESS_GAME_CTRL -- requirements
Module: guess_game_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the width of the secret and guess values.
REQ-002 The block SHALL have parameter MAX_TRIES, default 7, meaning the number of guesses allowed per round; legal range is 1..15.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port load, input, 1 bit: start-round strobe that captures the secret.
REQ-006 Port secret, input, N bits: secret value sampled on load.
REQ-007 Port guess_valid, input, 1 bit: a guess is offered.
REQ-008 Port guess, input, N bits: the guess value.
REQ-009 Port guess_ready, output, 1 bit: the block accepts a guess this cycle.
REQ-010 Port hint_valid, output, 1 bit: one-cycle pulse marking a valid hint.
REQ-011 Port hint_up, hint_down, hint_eq, output, 1 bit each: secret>guess, secret<guess, secret==guess; exactly one is high while hint_valid=1.
REQ-012 Port tries, output, 4 bits: count of guesses accepted in the current round.
REQ-013 Port win, output, 1 bit: sticky flag, round won.
REQ-014 Port lose, output, 1 bit: sticky flag, round lost.

Function
REQ-015 The FSM SHALL have states IDLE, ARMED, CMP, WIN and LOSE.
REQ-016 In any state, load=1 SHALL capture the secret, clear tries, win, lose and hint_valid, and go to ARMED next cycle; any pending hint is discarded.
REQ-017 guess_ready SHALL be 1 only in ARMED, and SHALL be driven from state only, with no combinational path from guess_valid.
REQ-018 In ARMED, guess_valid & guess_ready with load=0 SHALL register the guess, increment tries, and go to CMP.
REQ-019 In CMP, the registered secret and guess SHALL be compared using comparator8 (n=N) as main_number=secret, given_number=guess; gt drives hint_up, lt drives hint_down, eq drives hint_eq.
REQ-020 Hint outputs SHALL be registered, with hint_valid high for exactly the one cycle after CMP; the latency from the acceptance edge to hint_valid is 2 cycles.
REQ-021 Transitions out of CMP SHALL be: eq goes to WIN; otherwise tries==MAX_TRIES goes to LOSE; otherwise return to ARMED.
REQ-022 In WIN and LOSE, win or lose respectively SHALL stay high, guess_ready=0 and guesses are ignored, until load or rst.
REQ-023 Comparison SHALL be unsigned over the full N bits; boundary values 0 and 2^N-1 SHALL produce correct hints.
REQ-024 A guess equal to the secret on attempt MAX_TRIES SHALL produce WIN, not LOSE.
REQ-025 tries SHALL never exceed MAX_TRIES and SHALL never wrap.
REQ-026 hint_up, hint_down and hint_eq SHALL hold their last values between hint_valid pulses.

Reset
REQ-027 rst=1 SHALL force state IDLE, with guess_ready=0, hint_valid=0, hint_up=0, hint_down=0, hint_eq=0, tries=0, win=0, lose=0, and the internal secret and guess registers at 0.
REQ-028 rst SHALL take priority over load and guess_valid in the same cycle, including mid-round and during CMP.
REQ-029 After rst deasserts, the block SHALL remain in IDLE until load.

Configuration
REQ-030 Macro GUESS_GAME_LFSR_EN, when defined, SHALL compile in an internal 8-bit Fibonacci LFSR with taps x^8+x^6+x^5+x^4+1 and seed 8'h5A on rst, advancing every clock.
REQ-031 With the macro defined, load SHALL capture the LFSR value, zero-extended or truncated to N bits, and the secret port SHALL be ignored.
REQ-032 Without the macro, no LFSR logic SHALL exist and load SHALL capture the secret port.

Verification
REQ-033 rst, then load with secret=8'd100, then guesses 50, 150, 100 -> hints up, down, eq, each 2 cycles after acceptance; win=1; tries=3.
REQ-034 MAX_TRIES=7, secret=8'd0, seven guesses of 8'd1 -> seven hint_down pulses, then lose=1, tries=7; an eighth guess_valid is not accepted (guess_ready=0).
REQ-035 secret=8'hFF, guess=8'hFF on the 7th try -> hint_eq, win=1, lose=0; secret=8'hFF, guess=8'h00 -> hint_up.
REQ-036 guess_valid held high continuously in ARMED -> a guess is accepted only every 3rd cycle, never during CMP or the hint cycle.
REQ-037 load asserted in the CMP cycle with secret=8'd7 -> no hint_valid pulse, tries=0, state ARMED; rst asserted together with load -> IDLE.
REQ-038 With GUESS_GAME_LFSR_EN defined: rst, then load on the first cycle -> secret=8'h5A (verified by guess 8'h5A giving hint_eq); the secret port value is ignored.
